nic_flit_injector: RTL and testbench

//  Network-interface transmit side for one router input port: accepts messages from a core,

---
 rtl/nic_flit_injector_if.sv | 33 +++
 rtl/nic_flit_injector.sv | 134 +++++++++++++
 tb/tb_nic_flit_injector.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nic_flit_injector_if.sv
// Core/router-facing handshake bundle for the NIC flit injector: message request side
// and flit/credit side toward one router input port.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

interface nic_flit_injector_if #(
    parameter int NUM_ROUTERS = 16
);
    localparam int FW           = `FLIT_DATA_WIDTH;
    localparam int RIB          = $clog2(NUM_ROUTERS);
    localparam int PAYLOAD_BITS = FW - 2 * RIB;

    logic                    req_valid;
    logic [RIB-1:0]          req_dest;
    logic [PAYLOAD_BITS-1:0] req_payload;
    logic                    req_ready;
    logic                    credit_inc;
    logic [FW-1:0]           flit_data;
    logic                    flit_valid;

    // Core and router side
    modport master (
        output req_valid, req_dest, req_payload, credit_inc,
        input  req_ready, flit_data, flit_valid
    );

    // Injector side
    modport slave (
        input  req_valid, req_dest, req_payload, credit_inc,
        output req_ready, flit_data, flit_valid
    );
endinterface

// File: rtl/nic_flit_injector.sv
// NIC transmit side: queues core messages, builds flits and injects them into one router
// input port under credit-based flow control (one credit per downstream VC).
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module nic_flit_injector #(
    parameter int NUM_VC       = 4,
    parameter int NUM_ROUTERS  = 16,
    parameter int ROUTER_ID    = 0,
    parameter int QUEUE_DEPTH  = 4,
    parameter int PAYLOAD_BITS = `FLIT_DATA_WIDTH - 2 * $clog2(NUM_ROUTERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    nic_flit_injector_if.slave               bus,
    output logic [$clog2(NUM_VC+1)-1:0]      credit_count,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] fifo_count,
    output logic                             credit_err
);
    localparam int FW      = `FLIT_DATA_WIDTH;
    localparam int RIB     = $clog2(NUM_ROUTERS);
    localparam int CW      = $clog2(NUM_VC + 1);
    localparam int QW      = $clog2(QUEUE_DEPTH + 1);
    localparam int PW      = $clog2(QUEUE_DEPTH);
    localparam int ENTRY_W = RIB + PAYLOAD_BITS;

    localparam logic [RIB-1:0] SRC_ID  = RIB'(ROUTER_ID);
    localparam logic [CW-1:0]  MAX_CR  = CW'(NUM_VC);
    localparam logic [QW-1:0]  MAX_OCC = QW'(QUEUE_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] BLOCKED = 2'd2;

    logic [ENTRY_W-1:0] fifo_mem [QUEUE_DEPTH];
    logic [ENTRY_W-1:0] head;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [QW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] credit_count_q, credit_count_d;
    logic          credit_err_q, credit_err_d;
    logic [FW-1:0] flit_data_q, flit_data_d;
    logic          flit_valid_q, flit_valid_d;
    logic [1:0]    state_q, state_d;

    logic req_ready;
    logic push;
    logic send;

    assign req_ready = fifo_count_q < MAX_OCC;
    assign push      = bus.req_valid && req_ready;
    assign send      = (fifo_count_q != '0) && (credit_count_q != '0);
    assign head      = fifo_mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_count_d   = fifo_count_q;
        credit_count_d = credit_count_q;
        credit_err_d   = credit_err_q;
        flit_data_d    = flit_data_q;
        flit_valid_d   = send;
        state_d        = state_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (send) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, send})
            2'b10:   fifo_count_d = fifo_count_q + QW'(1);
            2'b01:   fifo_count_d = fifo_count_q - QW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        // A return that coincides with a send cancels it, so only a lone return can overflow.
        case ({send, bus.credit_inc})
            2'b10: credit_count_d = credit_count_q - CW'(1);
            2'b01: begin
                if (credit_count_q == MAX_CR) credit_err_d   = 1'b1;
                else                          credit_count_d = credit_count_q + CW'(1);
            end
            default: credit_count_d = credit_count_q;
        endcase

        if (send) flit_data_d = {head[ENTRY_W-1 -: RIB], SRC_ID, head[PAYLOAD_BITS-1:0]};

        case (state_q)
            IDLE:    if (push) state_d = ACTIVE;
            ACTIVE: begin
                if (fifo_count_d == '0)          state_d = IDLE;
                else if (credit_count_d == '0)   state_d = BLOCKED;
            end
            BLOCKED: if (bus.credit_inc) state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_count_q   <= '0;
            credit_count_q <= MAX_CR;
            credit_err_q   <= 1'b0;
            flit_data_q    <= '0;
            flit_valid_q   <= 1'b0;
            state_q        <= IDLE;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_count_q   <= fifo_count_d;
            credit_count_q <= credit_count_d;
            credit_err_q   <= credit_err_d;
            flit_data_q    <= flit_data_d;
            flit_valid_q   <= flit_valid_d;
            state_q        <= state_d;
        end
    end

    // NOTE: storage is not reset; occupancy is tracked by the pointers and count, so stale
    // entries are never read, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.req_dest, bus.req_payload};
    end

    assign bus.req_ready  = req_ready;
    assign bus.flit_data  = flit_data_q;
    assign bus.flit_valid = flit_valid_q;
    assign credit_count   = credit_count_q;
    assign fifo_count     = fifo_count_q;
    assign credit_err     = credit_err_q;
endmodule

// File: tb/tb_nic_flit_injector.sv
// Directed bench for nic_flit_injector: single flit, credit blocking, credit collision,
// FIFO back-pressure, credit overflow and mid-operation reset.
module tb_nic_flit_injector;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] credit_count;
    logic [2:0] fifo_count;
    logic       credit_err;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    nic_flit_injector_if #(.NUM_ROUTERS(16)) bus ();

    nic_flit_injector #(
        .NUM_VC(4), .NUM_ROUTERS(16), .ROUTER_ID(5), .QUEUE_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .credit_count(credit_count), .fifo_count(fifo_count), .credit_err(credit_err)
    );

    // Message i: dest = i+3 (mod 16), payload = 0x5A0000 + i; source field is always 5.
    function automatic logic [31:0] mk_flit(input int i);
        return {4'(i + 3), 4'h5, 24'h5A0000 + 24'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_msg(input int i);
        bus.req_valid   = 1'b1;
        bus.req_dest    = 4'(i + 3);
        bus.req_payload = 24'h5A0000 + 24'(i);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_dest    = '0;
        bus.req_payload = '0;
        bus.credit_inc  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic return_credits(input int n);
        bus.credit_inc = 1'b1;
        for (int k = 0; k < n; k++) tick();
        bus.credit_inc = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flit_valid: got %b want 0", bus.flit_valid); end
        n_checks++; if (bus.flit_data !== 32'h0) begin n_fail++; $display("FAIL rst_flit_data: got %h want 0", bus.flit_data); end
        n_checks++; if (credit_count !== 3'd4) begin n_fail++; $display("FAIL rst_credit: got %0d want 4", credit_count); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_fifo: got %0d want 0", fifo_count); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL rst_credit_err: got %b want 0", credit_err); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, S_IDLE); end
    endtask

    task automatic test_single_flit();
        bus.req_valid   = 1'b1;
        bus.req_dest    = 4'd10;
        bus.req_payload = 24'hABCDEF;
        tick();
        bus.req_valid = 1'b0;
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_fifo_after_push: got %0d want 1", fifo_count); end
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", bus.flit_valid); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.flit_valid); end
        n_checks++; if (bus.flit_data !== 32'hA5ABCDEF) begin n_fail++; $display("FAIL single_data: got %h want a5abcdef", bus.flit_data); end
        n_checks++; if (credit_count !== 3'd3) begin n_fail++; $display("FAIL single_credit: got %0d want 3", credit_count); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", bus.flit_valid); end
        n_checks++; if (bus.flit_data !== 32'hA5ABCDEF) begin n_fail++; $display("FAIL single_hold: got %h want a5abcdef", bus.flit_data); end
        return_credits(1);
        n_checks++; if (credit_count !== 3'd4) begin n_fail++; $display("FAIL single_credit_back: got %0d want 4", credit_count); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL single_no_err: got %b want 0", credit_err); end
    endtask

    task automatic test_credit_block();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_msg(i);
            tick();
            n_checks++; if (bus.flit_valid !== (i >= 1 && i <= 4)) begin n_fail++; $display("FAIL block_valid_%0d: got %b", i, bus.flit_valid); end
            if (i >= 1 && i <= 4) begin
                n_checks++; if (bus.flit_data !== mk_flit(i - 1)) begin n_fail++; $display("FAIL block_data_%0d: got %h want %h", i, bus.flit_data, mk_flit(i - 1)); end
            end
        end
        bus.req_valid = 1'b0;
        tick();
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL block_stall: got %b want 0", bus.flit_valid); end
        n_checks++; if (credit_count !== 3'd0) begin n_fail++; $display("FAIL block_credit: got %0d want 0", credit_count); end
        n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL block_fifo: got %0d want 2", fifo_count); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL block_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (dut.state_q !== S_BLOCKED) begin n_fail++; $display("FAIL block_state: got %0d want %0d", dut.state_q, S_BLOCKED); end
        return_credits(1);
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL block_inc_no_send: got %b want 0", bus.flit_valid); end
        n_checks++; if (credit_count !== 3'd1) begin n_fail++; $display("FAIL block_inc_credit: got %0d want 1", credit_count); end
        n_checks++; if (dut.state_q !== S_ACTIVE) begin n_fail++; $display("FAIL block_unblock_state: got %0d want %0d", dut.state_q, S_ACTIVE); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== mk_flit(4)) begin n_fail++; $display("FAIL block_fifth: got %b/%h want 1/%h", bus.flit_valid, bus.flit_data, mk_flit(4)); end
        n_checks++; if (credit_count !== 3'd0) begin n_fail++; $display("FAIL block_fifth_credit: got %0d want 0", credit_count); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL block_fifth_fifo: got %0d want 1", fifo_count); end
        return_credits(1);
        tick();
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== mk_flit(5)) begin n_fail++; $display("FAIL block_sixth: got %b/%h want 1/%h", bus.flit_valid, bus.flit_data, mk_flit(5)); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL block_idle_state: got %0d want %0d", dut.state_q, S_IDLE); end
        return_credits(4);
        n_checks++; if (credit_count !== 3'd4) begin n_fail++; $display("FAIL block_restore: got %0d want 4", credit_count); end
    endtask

    task automatic test_credit_collide();
        do_reset();
        drive_msg(10);
        tick();
        drive_msg(11);
        tick();
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== mk_flit(10)) begin n_fail++; $display("FAIL coll_first: got %b/%h want 1/%h", bus.flit_valid, bus.flit_data, mk_flit(10)); end
        bus.req_valid = 1'b0;
        tick();
        n_checks++; if (bus.flit_data !== mk_flit(11)) begin n_fail++; $display("FAIL coll_second: got %h want %h", bus.flit_data, mk_flit(11)); end
        n_checks++; if (credit_count !== 3'd2) begin n_fail++; $display("FAIL coll_credit2: got %0d want 2", credit_count); end
        drive_msg(12);
        tick();
        bus.req_valid  = 1'b0;
        bus.credit_inc = 1'b1;
        tick();
        bus.credit_inc = 1'b0;
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== mk_flit(12)) begin n_fail++; $display("FAIL coll_third: got %b/%h want 1/%h", bus.flit_valid, bus.flit_data, mk_flit(12)); end
        n_checks++; if (credit_count !== 3'd2) begin n_fail++; $display("FAIL coll_credit_same: got %0d want 2", credit_count); end
        tick();
        n_checks++; if (credit_count !== 3'd2 || bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL coll_settle: got %0d/%b want 2/0", credit_count, bus.flit_valid); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_msg(20 + i);
            tick();
        end
        n_checks++; if (fifo_count !== 3'd4 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got fifo %0d ready %b want 4/0", fifo_count, bus.req_ready); end
        drive_msg(28);
        tick();
        tick();
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_held: got %0d want 4", fifo_count); end
        return_credits(1);
        n_checks++; if (fifo_count !== 3'd4 || credit_count !== 3'd1) begin n_fail++; $display("FAIL full_inc: got fifo %0d credit %0d want 4/1", fifo_count, credit_count); end
        tick();
        n_checks++; if (bus.flit_data !== mk_flit(24) || fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_pop_refuse_push: got %h fifo %0d want %h/3", bus.flit_data, fifo_count, mk_flit(24)); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b want 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", fifo_count); end
        for (int j = 0; j < 5; j++) begin
            bus.credit_inc = (j < 4);
            tick();
            n_checks++; if (bus.flit_valid !== (j >= 1)) begin n_fail++; $display("FAIL drain_valid_%0d: got %b", j, bus.flit_valid); end
            if (j >= 1) begin
                n_checks++; if (bus.flit_data !== mk_flit(24 + j)) begin n_fail++; $display("FAIL drain_order_%0d: got %h want %h", j, bus.flit_data, mk_flit(24 + j)); end
            end
        end
        bus.credit_inc = 1'b0;
        n_checks++; if (fifo_count !== 3'd0 || credit_count !== 3'd0) begin n_fail++; $display("FAIL drain_end: got fifo %0d credit %0d want 0/0", fifo_count, credit_count); end
    endtask

    task automatic test_credit_overflow();
        do_reset();
        return_credits(1);
        n_checks++; if (credit_count !== 3'd4) begin n_fail++; $display("FAIL ovf_saturate: got %0d want 4", credit_count); end
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set: got %b want 1", credit_err); end
        for (int k = 0; k < 3; k++) tick();
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b want 1", credit_err); end
        do_reset();
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %b want 0", credit_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_msg(40 + i);
            tick();
        end
        bus.req_valid = 1'b0;
        return_credits(1);
        n_checks++; if (fifo_count !== 3'd3 || credit_count !== 3'd1) begin n_fail++; $display("FAIL mid_setup: got fifo %0d credit %0d want 3/1", fifo_count, credit_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (fifo_count !== 3'd0 || credit_count !== 3'd4 || bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got fifo %0d credit %0d valid %b want 0/4/0", fifo_count, credit_count, bus.flit_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (bus.flit_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_stale_%0d: got valid %b fifo %0d want 0/0", k, bus.flit_valid, fifo_count); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_flit();
        test_credit_block();
        test_credit_collide();
        test_full_backpressure();
        test_credit_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
